countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  Down-counting companion to the game's up-counting seconds timer: loads a start value in seconds,
//  decrements once per second while running and flags expiry. Drives round/turn time limits.
//  Sits beside the up-timer on the same clk domain; its tick is derived locally from CLK_FREQ.
// PARAMETERS
//  TIMER_WIDTH  16          width of loaded/remaining seconds value
//  CLK_FREQ     36_000_000  clk cycles per second (>= 2); prescaler width = $clog2(CLK_FREQ)
// PORTS
//  clk            in   1            system clock
//  rst_n          in   1            reset, asynchronous, active-low
//  i_load         in   1            load i_load_value, clear prescaler, go IDLE
//  i_load_value   in   TIMER_WIDTH  seconds to count down from
//  i_start        in   1            IDLE -> RUN (one-cycle strobe)
//  i_pause        in   1            level; high freezes counting in RUN
//  i_abort        in   1            clear remaining and prescaler, go IDLE
//  o_remaining    out  TIMER_WIDTH  seconds left
//  o_running      out  1            high in RUN
//  o_paused       out  1            high in PAUSE
//  o_expired      out  1            one-cycle pulse on reaching zero
//  o_done         out  1            level; high in DONE until load/abort/start
// BEHAVIOUR
//  - Reset: state IDLE, o_remaining=0, prescaler=0, all flags 0.
//  - States: IDLE, RUN, PAUSE, DONE. Command priority per cycle: i_abort > i_load > i_start > i_pause.
//  - IDLE: i_start && remaining!=0 -> RUN; i_start && remaining==0 -> DONE, o_expired pulses next cycle.
//  - RUN: prescaler increments each cycle; at CLK_FREQ-1 it wraps to 0 and remaining decrements.
//    Decrement 1->0 -> DONE; o_expired high in the cycle o_remaining first reads 0.
//    i_pause high -> PAUSE the next cycle; the cycle pause is sampled does not advance prescaler.
//  - PAUSE: prescaler and remaining hold (not cleared); i_pause low -> RUN, resumes from held phase.
//  - DONE: o_done=1, remaining=0; i_start re-enters RUN only after i_load with nonzero value
//    (i_start with remaining==0 in DONE: stay DONE, no new pulse).
//  - i_load in any state: remaining<=i_load_value, prescaler<=0, state<=IDLE, next cycle. No pulse.
//  - i_abort in any state: remaining<=0, prescaler<=0, state<=IDLE. No o_expired pulse.
//  - remaining never underflows; decrement only when remaining!=0.
//  - Async reset mid-count: immediate return to reset values; no pulse on release.
//  - All outputs registered; command-to-state latency 1 cycle.
// CONFIGURATION
//  COUNTDOWN_AUTO_RELOAD_EN defined: i_load_value latched into reload register on i_load; on expiry
//   remaining<=reload value, prescaler<=0, state stays RUN, o_expired still pulses one cycle, o_done
//   never asserts while reload value !=0. Reload value 0 behaves as undefined macro.
//  Undefined: expiry always goes to DONE and stays (behaviour above).
// STRUCTURE
//  - timer_pkg: typedef enum logic [1:0] {CD_IDLE, CD_RUN, CD_PAUSE, CD_DONE} cd_state_t;
//    shared CLK_FREQ default constant used by both timers.
//  - Sub-module tick_prescaler (CLK_FREQ): i_en, i_clr -> o_tick one-cycle at wrap; reusable by the up-timer.
//  - Top holds FSM, remaining counter, reload register (when enabled).
// TESTING  (CLK_FREQ=4)
//  - load 3, start -> o_remaining 3,2,1,0 every 4 cycles; o_expired single pulse with remaining=0; o_done=1.
//  - load 5, start, pause 6 cycles mid-second -> expiry delayed exactly 6 cycles; prescaler phase kept.
//  - load 0, start -> DONE, one o_expired pulse; second start -> no pulse.
//  - running at 2, abort+load+start same cycle -> abort wins: remaining 0, IDLE, no pulse.
//  - rst_n low mid-RUN for 1 cycle -> all outputs 0 immediately; no pulse after release.
//  - with COUNTDOWN_AUTO_RELOAD_EN, load 2, start -> remaining 2,1,0->2... pulse every 8 cycles, o_done=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Types and constants shared by the game's up-counting and down-counting seconds timers.
package timer_pkg;

  typedef enum logic [1:0] {CD_IDLE, CD_RUN, CD_PAUSE, CD_DONE} cd_state_t;

  localparam int unsigned TIMER_CLK_FREQ = 36_000_000;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_FREQ enabled cycles; i_clr restarts the phase.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ = TIMER_CLK_FREQ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = $clog2(CLK_FREQ);
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

  logic [CW-1:0] cnt_q;

  // Tick marks the enabled cycle in which the counter wraps to zero.
  assign o_tick = i_en && !i_clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Seconds down-counter with pause, abort and expiry flag for round/turn time limits.
// Optional COUNTDOWN_AUTO_RELOAD_EN: restart from the last loaded value on expiry.
//
// state    | meaning
// CD_IDLE  | loaded or aborted, waiting for start
// CD_RUN   | counting down once per second
// CD_PAUSE | counting frozen, prescaler phase and remaining held
// CD_DONE  | reached zero, waiting for load/abort
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH = 16,
  parameter int unsigned CLK_FREQ    = TIMER_CLK_FREQ
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_load,
  input  logic [TIMER_WIDTH-1:0] i_load_value,
  input  logic                   i_start,
  input  logic                   i_pause,
  input  logic                   i_abort,
  output logic [TIMER_WIDTH-1:0] o_remaining,
  output logic                   o_running,
  output logic                   o_paused,
  output logic                   o_expired,
  output logic                   o_done
);

  cd_state_t state_q, state_d;
  logic [TIMER_WIDTH-1:0] rem_q, rem_d;
  logic [TIMER_WIDTH-1:0] reload_val;
  logic expired_q, expired_d;
  logic running_q, paused_q, done_q;
  logic presc_en, presc_clr, tick;

  // Prescaler control depends only on inputs and state, keeping tick out of any loop.
  assign presc_clr = i_abort || i_load;
  assign presc_en  = ((state_q == CD_RUN) || (state_q == CD_PAUSE)) && !i_pause;

  tick_prescaler #(.CLK_FREQ(CLK_FREQ)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (presc_en),
    .i_clr  (presc_clr),
    .o_tick (tick)
  );

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [TIMER_WIDTH-1:0] reload_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q <= '0;
    end else if (!i_abort && i_load) begin
      reload_q <= i_load_value;
    end
  end

  assign reload_val = reload_q;
`else
  assign reload_val = '0;
`endif

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    expired_d = 1'b0;
    if (i_abort) begin
      state_d = CD_IDLE;
      rem_d   = '0;
    end else if (i_load) begin
      state_d = CD_IDLE;
      rem_d   = i_load_value;
    end else begin
      case (state_q)
        CD_IDLE: begin
          if (i_start) begin
            if (rem_q != '0) begin
              state_d = CD_RUN;
            end else begin
              state_d   = CD_DONE;
              expired_d = 1'b1;
            end
          end
        end
        CD_RUN, CD_PAUSE: begin
          state_d = i_pause ? CD_PAUSE : CD_RUN;
          if (tick && (rem_q != '0)) begin
            if (rem_q == TIMER_WIDTH'(1)) begin
              expired_d = 1'b1;
              // Prescaler wraps to zero on its own here, so reload needs no clear.
              if (reload_val != '0) begin
                rem_d   = reload_val;
                state_d = CD_RUN;
              end else begin
                rem_d   = '0;
                state_d = CD_DONE;
              end
            end else begin
              rem_d = rem_q - TIMER_WIDTH'(1);
            end
          end
        end
        CD_DONE: begin
          rem_d = '0;
        end
        default: begin
          state_d = CD_IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CD_IDLE;
      rem_q     <= '0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      expired_q <= expired_d;
      running_q <= (state_d == CD_RUN);
      paused_q  <= (state_d == CD_PAUSE);
      done_q    <= (state_d == CD_DONE);
    end
  end

  assign o_remaining = rem_q;
  assign o_running   = running_q;
  assign o_paused    = paused_q;
  assign o_expired   = expired_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer at CLK_FREQ=4 with hand-computed expectations.
module tb_countdown_timer;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_load, i_start, i_pause, i_abort;
  logic [15:0] i_load_value;
  logic [15:0] o_remaining;
  logic        o_running, o_paused, o_expired, o_done;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int n;

  countdown_timer #(.TIMER_WIDTH(16), .CLK_FREQ(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (i_load),
    .i_load_value (i_load_value),
    .i_start      (i_start),
    .i_pause      (i_pause),
    .i_abort      (i_abort),
    .o_remaining  (o_remaining),
    .o_running    (o_running),
    .o_paused     (o_paused),
    .o_expired    (o_expired),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (o_expired) pulses++;
  endtask

  task automatic load(input logic [15:0] v);
    i_load = 1'b1; i_load_value = v;
    step();
    i_load = 1'b0;
  endtask

  task automatic start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_load = 1'b0; i_start = 1'b0; i_pause = 1'b0; i_abort = 1'b0;
    i_load_value = '0;
    #1;
    chk("reset_rem", o_remaining, 0);
    chk("reset_flags", {o_running, o_paused, o_expired, o_done}, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", {o_running, o_paused, o_expired, o_done}, 0);

    // load 3, start: 3,2,1,0 at 4-cycle spacing
    pulses = 0;
    load(16'd3);
    chk("t1_loaded", o_remaining, 3);
    start();
    chk("t1_running", o_running, 1);
    repeat (3) step();
    chk("t1_rem3_hold", o_remaining, 3);
    step();
    chk("t1_rem2", o_remaining, 2);
    repeat (4) step();
    chk("t1_rem1", o_remaining, 1);
    repeat (3) step();
    chk("t1_no_early_pulse", o_expired, 0);
    step();
    chk("t1_expired", o_expired, 1);
    chk("t1_rem_at_expiry", o_remaining, RELOAD ? 3 : 0);
    chk("t1_done", o_done, RELOAD ? 0 : 1);
    step();
    chk("t1_expired_cleared", o_expired, 0);
    chk("t1_done_level", o_done, RELOAD ? 0 : 1);
    chk("t1_running_after", o_running, RELOAD ? 1 : 0);
    chk("t1_one_pulse", pulses, 1);

    // load 5, pause for 6 cycles mid-second: expiry 26 cycles after start
    load(16'd5);
    start();
    step(); step();
    i_pause = 1'b1;
    step();
    chk("t2_paused", o_paused, 1);
    chk("t2_not_running", o_running, 0);
    repeat (5) step();
    chk("t2_rem_held", o_remaining, 5);
    i_pause = 1'b0;
    step();
    chk("t2_resumed", {o_running, o_paused}, 2'b10);
    chk("t2_rem_before_tick", o_remaining, 5);
    step();
    chk("t2_phase_kept", o_remaining, 4);
    n = 0;
    while (!o_expired && n < 40) begin
      step();
      n++;
    end
    chk("t2_expiry_cycle", 10 + n, 26);

    // load during RUN returns to IDLE and clears prescaler phase
    pulses = 0;
    load(16'd4);
    start();
    step(); step();
    load(16'd9);
    chk("t3_reload_idle", {o_running, o_remaining}, {1'b0, 16'd9});
    start();
    repeat (3) step();
    chk("t3_rem9_hold", o_remaining, 9);
    step();
    chk("t3_rem8", o_remaining, 8);
    chk("t3_no_pulse", pulses, 0);

    // abort + load + start in the same cycle at remaining 2: abort wins
    load(16'd5);
    start();
    n = 0;
    while (o_remaining != 16'd2 && n < 30) begin
      step();
      n++;
    end
    chk("t4_reached_2", o_remaining, 2);
    step();
    pulses = 0;
    i_abort = 1'b1; i_load = 1'b1; i_load_value = 16'd7; i_start = 1'b1;
    step();
    i_abort = 1'b0; i_load = 1'b0; i_start = 1'b0;
    chk("t4_abort_rem", o_remaining, 0);
    chk("t4_abort_flags", {o_running, o_paused, o_expired, o_done}, 0);
    repeat (10) step();
    chk("t4_stays_idle", {o_running, o_remaining}, 0);
    chk("t4_no_pulse", pulses, 0);

    // load 0, start: straight to DONE with one pulse; second start gives none
    pulses = 0;
    load(16'd0);
    start();
    chk("t5_done", o_done, 1);
    chk("t5_expired", o_expired, 1);
    step();
    chk("t5_expired_cleared", o_expired, 0);
    start();
    chk("t5_second_start", {o_running, o_expired, o_done}, 3'b001);
    chk("t5_one_pulse", pulses, 1);

    // async reset mid-RUN
    load(16'd3);
    start();
    repeat (4) step();
    chk("t6_pre_reset", {o_running, o_remaining}, {1'b1, 16'd2});
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_rem", o_remaining, 0);
    chk("t6_async_flags", {o_running, o_paused, o_expired, o_done}, 0);
    step();
    rst_n = 1'b1;
    pulses = 0;
    repeat (20) step();
    chk("t6_after_release", {o_running, o_done, o_remaining}, 0);
    chk("t6_no_pulse", pulses, 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // auto reload: load 2, pulse every 8 cycles, never done
    pulses = 0;
    load(16'd2);
    start();
    repeat (8) step();
    chk("t7_first_pulse", o_expired, 1);
    chk("t7_reloaded", o_remaining, 2);
    chk("t7_still_running", {o_running, o_done}, 2'b10);
    repeat (7) step();
    chk("t7_between", {o_expired, o_remaining}, {1'b0, 16'd1});
    step();
    chk("t7_second_pulse", {o_expired, o_remaining}, {1'b1, 16'd2});
    chk("t7_pulse_count", pulses, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
